// File: rtl/perceptron_trainer.sv
// Training sequencer for a pipelined perceptron. It presents stored labelled samples one at a time,
// checks the perceptron's y output LATENCY cycles later, and repeats epochs until one has no errors.
module perceptron_trainer #(
  parameter int N          = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = 4,
  parameter int LATENCY    = 3,
  parameter int MAX_EPOCHS = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [N-1:1]  load_x,
  input  logic [31:0]   load_y,
  input  logic [AW:0]   num_samples,
  input  logic [31:0]   lr_in,
  input  logic          start,
  output logic [N-1:1]  x,
  output logic          train,
  output logic [31:0]   learning_rate,
  output logic [31:0]   expected_y,
  input  logic [31:0]   y,
  output logic          busy,
  output logic          done,
  output logic          converged,
  output logic [7:0]    epoch_count,
  output logic [AW:0]   error_count
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, SETTLE, EPOCH_END, DONE} state_t;

  state_t        state, state_next;
  logic [N-1:1]  mem_x [DEPTH];
  logic [31:0]   mem_y [DEPTH];
  logic [AW:0]   idx, idx_next, count, err_cnt, ns_clamped;
  logic [31:0]   lr_lat;
  logic [7:0]    wait_cnt, epoch_inc;
  logic          idle_like, accept;

  assign idle_like  = (state == IDLE) || (state == DONE);
  assign accept     = start && idle_like;
  assign busy       = !idle_like;
  // Combinational on state so that an asynchronous reset drops the pulse at once.
  assign train      = (state == ISSUE);
  assign ns_clamped = (num_samples > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_samples;
  assign epoch_inc  = (epoch_count == 8'hFF) ? epoch_count : epoch_count + 8'd1;

  always_ff @(posedge clk) begin
    if (load_en && idle_like) begin
      mem_x[load_addr] <= load_x;
      mem_y[load_addr] <= load_y;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          idx_next   = '0;
          state_next = (ns_clamped == '0) ? DONE : ISSUE;
        end
      end
      ISSUE:  state_next = (LATENCY > 1) ? WAIT : CHECK;
      WAIT:   if (wait_cnt == '0) state_next = CHECK;
      CHECK:  state_next = SETTLE;
      SETTLE: begin
        idx_next   = idx + 1'b1;
        state_next = (idx_next == count) ? EPOCH_END : ISSUE;
      end
      EPOCH_END: begin
        if (err_cnt == '0 || epoch_inc == 8'(MAX_EPOCHS)) begin
          state_next = DONE;
        end else begin
          idx_next   = '0;
          state_next = ISSUE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x             <= '0;
      learning_rate <= '0;
      expected_y    <= '0;
      done          <= 1'b0;
      converged     <= 1'b0;
      epoch_count   <= '0;
      error_count   <= '0;
      idx           <= '0;
      count         <= '0;
      err_cnt       <= '0;
      lr_lat        <= '0;
      wait_cnt      <= '0;
    end else begin
      idx <= idx_next;
      if (accept) begin
        lr_lat      <= lr_in;
        count       <= ns_clamped;
        done        <= (ns_clamped == '0);
        converged   <= (ns_clamped == '0);
        epoch_count <= '0;
        err_cnt     <= '0;
      end
      // Sample registers load on entry to ISSUE so they are valid during the train cycle.
      if (state_next == ISSUE) begin
        x             <= mem_x[idx_next[AW-1:0]];
        expected_y    <= mem_y[idx_next[AW-1:0]];
        learning_rate <= accept ? lr_in : lr_lat;
      end
      if (state == ISSUE) wait_cnt <= (LATENCY > 1) ? 8'(LATENCY - 2) : '0;
      if (state == WAIT)  wait_cnt <= wait_cnt - 8'd1;
      if (state == CHECK && y != expected_y && err_cnt != (AW+1)'(DEPTH))
        err_cnt <= err_cnt + 1'b1;
      if (state == EPOCH_END) begin
        error_count <= err_cnt;
        epoch_count <= epoch_inc;
        if (err_cnt == '0) begin
          converged <= 1'b1;
          done      <= 1'b1;
        end else if (epoch_inc == 8'(MAX_EPOCHS)) begin
          converged <= 1'b0;
          done      <= 1'b1;
        end else begin
          err_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: doc/perceptron_trainer.md
Name: perceptron_trainer

Overview:
- Training sequencer on the driving side of the perceptron's training interface.
- Holds a small labelled sample set loaded by a host, and presents samples one at a time on the perceptron's x / train / expected_y / learning_rate inputs.
- Samples the perceptron's y output, counts misclassifications per epoch, and repeats epochs until an epoch has zero errors or the epoch limit is hit.

Parameters:
- N, 8, perceptron input count; the x bus is [N-1:1].
- DEPTH, 16, sample memory entries (power of 2).
- AW, 4, address width, log2(DEPTH).
- LATENCY, 3, cycles from sample issue to the cycle y is compared (perceptron pipeline register stages).
- MAX_EPOCHS, 255, epoch limit (1..255).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- load_en  in  1  write a sample into memory this cycle.
- load_addr  in  AW  sample write address.
- load_x  in  N-1  sample input vector.
- load_y  in  32  sample expected output.
- num_samples  in  AW+1  samples per epoch; sampled at start.
- lr_in  in  32  learning rate; latched at start.
- start  in  1  begin training (pulse).
- x  out  N-1  to perceptron x.
- train  out  1  to perceptron train.
- learning_rate  out  32  to perceptron learning_rate.
- expected_y  out  32  to perceptron expected_y.
- y  in  32  from perceptron y.
- busy  out  1  high from the cycle after start until DONE.
- done  out  1  level; set on finish, cleared by next accepted start.
- converged  out  1  valid with done; high if the last epoch had 0 errors.
- epoch_count  out  8  epochs completed.
- error_count  out  AW+1  errors in the most recent completed epoch.

Behaviour:
- Reset (rst=0, async): state=IDLE; x=0, train=0, learning_rate=0, expected_y=0, busy=0, done=0, converged=0, epoch_count=0, error_count=0. Sample memory is not reset; contents are retained.
- Load: when load_en=1 and state is IDLE or DONE, mem[load_addr] <= {load_x, load_y} at the clock edge. load_en while busy is dropped.
- Start: accepted only in IDLE or DONE.
  - On acceptance: latch lr_in and min(num_samples, DEPTH); clear done, converged, epoch_count, error counter; sample index=0.
  - start while busy is ignored.
  - num_samples=0: go to DONE next cycle with converged=1, epoch_count=0.
- FSM: IDLE -> ISSUE -> WAIT -> CHECK -> SETTLE -> (ISSUE | EPOCH_END) -> (ISSUE | DONE).
- ISSUE (1 cycle):
  - x/expected_y driven from mem[idx]; learning_rate from the latched value; train=1.
  - x, expected_y and learning_rate stay registered and stable through SETTLE.
  - train is high only in ISSUE.
- WAIT: LATENCY-1 cycles, train=0. With LATENCY=1, WAIT is skipped.
- CHECK (1 cycle, exactly LATENCY cycles after ISSUE): if y != expected_y (exact 32-bit compare), increment the epoch error counter (saturating at DEPTH).
- SETTLE (1 cycle, train=0): lets the weight update land; idx++.
  - If idx reaches the latched count, go to EPOCH_END; else go to ISSUE.
- Per-sample period is LATENCY+2 cycles.
- EPOCH_END (1 cycle):
  - Update registers: error_count <= counter; epoch_count++ (saturating at 255).
  - If counter==0: converged=1, go to DONE.
  - Else if the new epoch_count==MAX_EPOCHS: converged=0, go to DONE.
  - Else clear the counter, idx=0, go to ISSUE.
- DONE: busy=0, done=1, train=0; outputs hold their last values. Go to ISSUE-path only on an accepted start.
- Reset mid-epoch: immediate return to the reset state. train drops asynchronously, so no spurious training pulse follows reset release.

Test Plan:
- Reset/idle: assert rst=0 mid-ISSUE -> train=0 immediately; all outputs at reset values; busy=0 after release.
- Convergent set: load 4 samples; a perceptron model returns y==expected_y from epoch 2 onward; start with num_samples=4, LATENCY=3.
  - Expect train pulses every 5 cycles.
  - Expect error_count=0, epoch_count=2, converged=1, done=1.
  - Expect 40 cycles busy plus EPOCH_END cycles.
- Non-convergent: model always returns y=~expected_y, MAX_EPOCHS=3, 2 samples -> done with converged=0, epoch_count=3, error_count=2.
- Compare timing: model returns a correct y only in the CHECK cycle and a wrong y in the others -> zero errors counted. The same pattern shifted one cycle earlier -> every sample counted as an error.
- Boundaries:
  - num_samples=0 -> done next cycle, converged=1.
  - num_samples=20 with DEPTH=16 -> exactly 16 train pulses per epoch.
- Ignored inputs: start and load_en asserted while busy -> no restart; memory unchanged (verified by readback via a subsequent run's expected_y values).
